// File: rtl/alto_mpc_sequencer.sv
// alto_mpc_sequencer: microprogram counter stage.
// Forms next microaddress = NEXT | modifiers, keeps one saved MPC per task,
// and swaps in the incoming task's saved MPC when TASK is decoded.
// Optional feature macro: ALTO_MPC_RAM_BANK_EN (adds swmode_i / bank_o with a
// per-task control-store bank bit).
module alto_mpc_sequencer #(
    parameter int unsigned TASKS  = 16,
    parameter int unsigned TASK_W = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
`ifdef ALTO_MPC_RAM_BANK_EN
    input  logic              swmode_i,
    output logic              bank_o,
`endif
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] next_i,
    input  logic [ADDR_W-1:0] modifiers_i,
    input  logic              task_switch_i,
    input  logic [TASK_W-1:0] next_task_i,
    output logic [ADDR_W-1:0] mpc_o,
    output logic [TASK_W-1:0] task_o,
    output logic              task_switched_o
);

    logic [ADDR_W-1:0] target;
    logic              do_switch;

    logic [ADDR_W-1:0] mpc_q,      mpc_d;
    logic [TASK_W-1:0] task_q,     task_d;
    logic              switched_q, switched_d;
    logic [ADDR_W-1:0] saved_q [TASKS];
    logic [ADDR_W-1:0] saved_d [TASKS];

    // Target address and task-change decode; a TASK naming the current task
    // is treated as a plain advance so the stale saved slot is never used.
    always_comb begin
        target    = next_i | modifiers_i;
        do_switch = !hold_i && task_switch_i && (next_task_i != task_q);
    end

    // Next-state for MPC, task and switch pulse.
    always_comb begin
        mpc_d      = mpc_q;
        task_d     = task_q;
        switched_d = 1'b0;
        if (!hold_i) begin
            if (do_switch) begin
                task_d     = next_task_i;
                mpc_d      = saved_q[next_task_i];
                switched_d = 1'b1;
            end else begin
                mpc_d = target;
            end
        end
    end

    // Current task's slot always captures the target, even when switching out;
    // the incoming slot is read from the pre-edge flops above.
    always_comb begin
        for (int unsigned t = 0; t < TASKS; t++) begin
            saved_d[t] = saved_q[t];
            if (!hold_i && (task_q == TASK_W'(t))) begin
                saved_d[t] = target;
            end
        end
    end

    // State registers; every saved slot boots to its own task number.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mpc_q      <= '0;
            task_q     <= '0;
            switched_q <= 1'b0;
            for (int unsigned t = 0; t < TASKS; t++) begin
                saved_q[t] <= ADDR_W'(t);
            end
        end else begin
            mpc_q      <= mpc_d;
            task_q     <= task_d;
            switched_q <= switched_d;
            for (int unsigned t = 0; t < TASKS; t++) begin
                saved_q[t] <= saved_d[t];
            end
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        mpc_o           = mpc_q;
        task_o          = task_q;
        task_switched_o = switched_q;
    end

`ifdef ALTO_MPC_RAM_BANK_EN
    logic [TASKS-1:0] bank_q, bank_d;

    // SWMODE toggles the bank of the task executing now (the outgoing task
    // when combined with TASK).
    always_comb begin
        bank_d = bank_q;
        if (!hold_i && swmode_i) begin
            bank_d[task_q] = ~bank_q[task_q];
        end
    end

    // Per-task bank flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    // Bank of the current task.
    always_comb begin
        bank_o = bank_q[task_q];
    end
`endif

endmodule

// File: tb/tb_alto_mpc_sequencer.sv
// Self-checking bench for alto_mpc_sequencer (directed scenarios plus random
// traffic against a per-task behavioural model).
module tb_alto_mpc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0;
    logic [9:0] nxt = '0;
    logic [9:0] mods = '0;
    logic       tsw = 1'b0;
    logic [3:0] ntask = '0;
    logic [9:0] mpc;
    logic [3:0] tsk;
    logic       sw;
`ifdef ALTO_MPC_RAM_BANK_EN
    logic       swmode = 1'b0;
    logic       bank;
`endif

    int passed = 0;
    int total  = 0;

    // Behavioural model: one saved address per task, current pc/task/pulse.
    logic [9:0]  m_saved [16];
    logic [9:0]  m_mpc;
    logic [3:0]  m_task;
    logic        m_sw;
    logic [15:0] m_bank;

    alto_mpc_sequencer #(.TASKS(16), .TASK_W(4), .ADDR_W(10)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
`ifdef ALTO_MPC_RAM_BANK_EN
        .swmode_i        (swmode),
        .bank_o          (bank),
`endif
        .hold_i          (hold),
        .next_i          (nxt),
        .modifiers_i     (mods),
        .task_switch_i   (tsw),
        .next_task_i     (ntask),
        .mpc_o           (mpc),
        .task_o          (tsk),
        .task_switched_o (sw)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int t = 0; t < 16; t++) m_saved[t] = 10'(t);
        m_mpc  = '0;
        m_task = '0;
        m_sw   = 1'b0;
        m_bank = '0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic step();
        logic [9:0] tgt;
        logic [3:0] old_task;
        @(posedge clk);
        if (rst_n) begin
            if (hold) begin
                m_sw = 1'b0;
            end else begin
                tgt      = nxt | mods;
                old_task = m_task;
`ifdef ALTO_MPC_RAM_BANK_EN
                if (swmode) m_bank[old_task] = ~m_bank[old_task];
`endif
                if (tsw && ntask != old_task) begin
                    m_mpc  = m_saved[ntask];
                    m_task = ntask;
                    m_sw   = 1'b1;
                end else begin
                    m_mpc = tgt;
                    m_sw  = 1'b0;
                end
                m_saved[old_task] = tgt;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        total++;
        if ({mpc, tsk, sw} !== 15'd0) $display("FAIL reset_state got mpc=%h task=%0d sw=%b want 0/0/0", mpc, tsk, sw);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nxt = 10'h005; mods = '0;
        total++;
        if (mpc !== 10'h000 || tsk !== 4'd0) $display("FAIL pre_first_edge got mpc=%h task=%0d want 000/0", mpc, tsk);
        else passed++;
        step();
        total++;
        if (mpc !== 10'h005) $display("FAIL first_edge got mpc=%h want 005", mpc);
        else passed++;
    endtask

    task automatic test_or_target();
        nxt = 10'h120; mods = 10'h001;
        step();
        total++;
        if (mpc !== 10'h121) $display("FAIL or_target_a got mpc=%h want 121", mpc);
        else passed++;
        nxt = 10'h121; mods = 10'h001;
        step();
        total++;
        if (mpc !== 10'h121) $display("FAIL or_not_add got mpc=%h want 121", mpc);
        else passed++;
    endtask

    task automatic test_task_switch();
        nxt = 10'h040; mods = '0; tsw = 1'b1; ntask = 4'd5;
        step();
        total++;
        if ({mpc, tsk, sw} !== {10'h005, 4'd5, 1'b1}) $display("FAIL switch_in got mpc=%h task=%0d sw=%b want 005/5/1", mpc, tsk, sw);
        else passed++;
        tsw = 1'b0; nxt = 10'h010;
        step();
        total++;
        if ({mpc, tsk, sw} !== {10'h010, 4'd5, 1'b0}) $display("FAIL pulse_end got mpc=%h task=%0d sw=%b want 010/5/0", mpc, tsk, sw);
        else passed++;
        tsw = 1'b1; ntask = 4'd0; nxt = 10'h077;
        step();
        total++;
        if ({mpc, tsk, sw} !== {10'h040, 4'd0, 1'b1}) $display("FAIL switch_back got mpc=%h task=%0d sw=%b want 040/0/1", mpc, tsk, sw);
        else passed++;
        ntask = 4'd5;
        step();
        total++;
        if (mpc !== 10'h077 || tsk !== 4'd5) $display("FAIL resume_task5 got mpc=%h task=%0d want 077/5", mpc, tsk);
        else passed++;
        tsw = 1'b0;
    endtask

    task automatic test_same_task();
        tsw = 1'b1; ntask = 4'd3; nxt = 10'h100;
        step();
        total++;
        if (mpc !== 10'h003 || tsk !== 4'd3) $display("FAIL enter_task3 got mpc=%h task=%0d want 003/3", mpc, tsk);
        else passed++;
        nxt = 10'h2AA; mods = '0;
        step();
        total++;
        if ({mpc, tsk, sw} !== {10'h2AA, 4'd3, 1'b0}) $display("FAIL same_task got mpc=%h task=%0d sw=%b want 2aa/3/0", mpc, tsk, sw);
        else passed++;
        tsw = 1'b0;
    endtask

    task automatic test_hold();
        hold = 1'b1; tsw = 1'b1; ntask = 4'd7; nxt = 10'h3C3;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({mpc, tsk, sw} !== {10'h2AA, 4'd3, 1'b0}) $display("FAIL hold_cycle%0d got mpc=%h task=%0d sw=%b want 2aa/3/0", i, mpc, tsk, sw);
            else passed++;
        end
        hold = 1'b0; tsw = 1'b0; nxt = 10'h0F0;
        step();
        total++;
        if ({mpc, tsk, sw} !== {10'h0F0, 4'd3, 1'b0}) $display("FAIL hold_release got mpc=%h task=%0d sw=%b want 0f0/3/0", mpc, tsk, sw);
        else passed++;
        tsw = 1'b1; ntask = 4'd7;
        step();
        total++;
        if (mpc !== 10'h007 || tsk !== 4'd7) $display("FAIL slot7_untouched got mpc=%h task=%0d want 007/7", mpc, tsk);
        else passed++;
        tsw = 1'b0;
    endtask

    task automatic test_async_reset();
        tsw = 1'b1; ntask = 4'd9;
        step();
        tsw = 1'b0; nxt = 10'h3FF;
        step();
        total++;
        if (mpc !== 10'h3FF || tsk !== 4'd9) $display("FAIL pre_reset got mpc=%h task=%0d want 3ff/9", mpc, tsk);
        else passed++;
        hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mpc, tsk, sw} !== 15'd0) $display("FAIL async_reset got mpc=%h task=%0d sw=%b want 0/0/0", mpc, tsk, sw);
        else passed++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; hold = 1'b0; tsw = 1'b1; ntask = 4'd9;
        step();
        total++;
        if (mpc !== 10'h009 || tsk !== 4'd9) $display("FAIL reboot_task9 got mpc=%h task=%0d want 009/9", mpc, tsk);
        else passed++;
        tsw = 1'b1; ntask = 4'd0;
        step();
        tsw = 1'b0;
`ifdef ALTO_MPC_RAM_BANK_EN
        total++;
        if (bank !== 1'b0) $display("FAIL bank_reset got %b want 0", bank);
        else passed++;
        swmode = 1'b1;
        step();
        swmode = 1'b0;
        total++;
        if (bank !== 1'b1 || tsk !== 4'd0) $display("FAIL bank_toggle got bank=%b task=%0d want 1/0", bank, tsk);
        else passed++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            hold  = ($urandom_range(0, 3) == 0);
            tsw   = ($urandom_range(0, 9) < 3);
            ntask = ($urandom_range(0, 4) == 0) ? m_task : 4'($urandom_range(0, 15));
            nxt   = 10'($urandom);
            mods  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : '0;
`ifdef ALTO_MPC_RAM_BANK_EN
            swmode = ($urandom_range(0, 5) == 0);
`endif
            step();
            total++;
            if ({mpc, tsk, sw} !== {m_mpc, m_task, m_sw})
                $display("FAIL random_%0d got mpc=%h task=%0d sw=%b want %h/%0d/%b", i, mpc, tsk, sw, m_mpc, m_task, m_sw);
            else passed++;
`ifdef ALTO_MPC_RAM_BANK_EN
            total++;
            if (bank !== m_bank[m_task]) $display("FAIL random_bank_%0d got %b want %b", i, bank, m_bank[m_task]);
            else passed++;
`endif
        end
        hold = 1'b0; tsw = 1'b0;
`ifdef ALTO_MPC_RAM_BANK_EN
        swmode = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_or_target();
        test_task_switch();
        test_same_task();
        test_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alto_mpc_sequencer.md
Name: alto_mpc_sequencer

Overview:
Microprogram counter stage directly downstream of the common next-address modifier logic. Each cycle it forms the next microaddress as the microinstruction NEXT field ORed with the modifier vector. It keeps one saved MPC per task and switches tasks when TASK is decoded. It drives the control-store address and the current task number for the rest of the CPU.

Parameters:
TASKS, 16, number of microcode tasks; must equal 2**TASK_W
TASK_W, 4, task number width
ADDR_W, 10, microaddress width; must match the modifier vector width

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
hold_i  input  1  stall; when 1, no state changes this cycle
next_i  input  ADDR_W  NEXT field of the current microinstruction
modifiers_i  input  ADDR_W  branch modifier vector from upstream (F2-selected, task-specific bits already ORed in)
task_switch_i  input  1  F1=TASK decoded in the current microinstruction
next_task_i  input  TASK_W  highest-priority requesting task from the priority encoder, valid with task_switch_i
mpc_o  output  ADDR_W  current microaddress (control-store read address)
task_o  output  TASK_W  current task
task_switched_o  output  1  one-cycle pulse: the current instruction is the first after a task change

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n_i), all state in the clk_i domain.
- Reset values:
  - mpc_o = 0, task_o = 0, task_switched_o = 0.
  - Saved MPC slot t = t, for every t in 0..TASKS-1. Each task's boot vector equals its task number.
- Combinational target = next_i | modifiers_i, bitwise OR, ADDR_W bits, no carry.
- Per rising edge with hold_i = 0:
  - saved[task_o] <= target. The current task's slot is always written, including on the cycle it switches out.
  - If task_switch_i = 0: mpc_o <= target, task_o unchanged, task_switched_o <= 0.
  - If task_switch_i = 1 and next_task_i != task_o:
    - task_o <= next_task_i
    - mpc_o <= saved[next_task_i], the value before this edge's write
    - task_switched_o <= 1
  - If task_switch_i = 1 and next_task_i == task_o: mpc_o <= target, task_switched_o <= 0. The stale saved value is never used.
- hold_i = 1:
  - mpc_o, task_o and all saved slots keep their values.
  - task_switched_o <= 0.
  - hold_i overrides task_switch_i; a TASK request during hold is lost, and upstream re-presents it.
- Latency: the address produced by instruction N appears on mpc_o one edge later. No combinational path from any input to any output.
- Saved MPC storage: TASKS x ADDR_W flops (not RAM), so the slot write and the other slot's read happen in the same cycle.
- Reset asserted mid-operation: immediate return to reset values, regardless of hold_i.
- next_task_i is ignored when task_switch_i = 0.

Optional Feature:
ALTO_MPC_RAM_BANK_EN
- Enabled:
  - Adds input swmode_i (1 bit, F1=SWMODE decoded) and output bank_o (1 bit).
  - A per-task bank flop, reset 0, selects the control-store bank.
  - swmode_i = 1 with hold_i = 0 toggles the current task's bank at the edge, so the next instruction fetches from the other bank.
  - When task_switch_i and swmode_i are both 1, the outgoing task's bank toggles and bank_o shows the incoming task's bank.
  - bank_o always reflects the bank of task_o.
- Disabled: swmode_i and bank_o do not exist; no bank state is synthesised.

Test Plan:
1. Release reset, hold_i = 0, next_i = 10'h005, modifiers_i = 0 -> mpc_o = 0, task_o = 0 before the first edge; mpc_o = 10'h005 after the first edge.
2. next_i = 10'h120, modifiers_i = 10'h001 (BUS=0 true) -> mpc_o = 10'h121. Repeat with next_i = 10'h121, modifiers_i = 10'h001 -> mpc_o = 10'h121 (OR, not add).
3. In task 0, target 10'h040, task_switch_i = 1, next_task_i = 4'd5 -> task_o = 5, mpc_o = 10'h005, task_switched_o pulses one cycle. Later switch back to task 0 -> mpc_o = 10'h040.
4. Task 3 with task_switch_i = 1, next_task_i = 4'd3, target 10'h2AA -> task_o = 3, mpc_o = 10'h2AA, task_switched_o = 0.
5. hold_i = 1 for 3 cycles with task_switch_i = 1, next_task_i = 7 -> mpc_o, task_o unchanged and no pulse. Drop hold_i with task_switch_i = 0 -> normal advance in the old task.
6. Assert rst_n_i mid-run with task 9 at 10'h3FF -> mpc_o = 0 and task_o = 0 immediately, asynchronously. After release, switch to task 9 -> mpc_o = 10'h009. With ALTO_MPC_RAM_BANK_EN, bank_o = 0 after reset, and swmode_i in task 0 -> bank_o = 1 next cycle.
